// File: rtl/fifo_pkg.sv
// Shared types and helpers for the safe single-clock FIFO.
package fifo_pkg;

    // Sticky protocol-violation flags reported by the FIFO.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage for the safe FIFO: one write port and one synchronous read port.
// The array itself is never reset; only the registered read word is cleared.
module fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the accepted word into its slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Register the popped word; hold the last word when nothing is popped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/safe_sync_fifo.sv
// Single-clock FIFO that refuses illegal push/pop and records each violation
// in sticky flags. Optional embedded assertions: define SAFE_FIFO_SVA_EN.
module safe_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      pop,
    output logic [WIDTH-1:0]          data_out,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    fifo_err_t     err;

    // Status comes straight from the occupancy register, so it is never stale.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign overflow  = err.overflow;
    assign underflow = err.underflow;

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    // Pointers, occupancy and read-valid; rejected requests leave them untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rd_valid <= pop_ok;
        end
    end

    // Sticky violation flags; a fresh violation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err.overflow  <= (push & full)  | (err.overflow  & ~err_clr);
            err.underflow <= (pop  & empty) | (err.underflow & ~err_clr);
        end
    end

`ifdef SAFE_FIFO_SVA_EN
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));
    a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(full && empty));
    a_flag_decode: assert property (@(posedge clk) disable iff (!rst_n)
        ((count == '0) == empty) && ((count == CW'(DEPTH)) == full));
    a_count_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(count));
    a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        push_ok |-> !$isunknown(data_in));
    a_count_rule: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> (count == CW'($past(count) + CW'($past(push_ok)) - CW'($past(pop_ok)))));
`endif

endmodule
